// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_pkg
//  Description : Shared types and constants for the counter sequencing
//                controller: FSM state encoding, job status codes, and the
//                X-propagation helper macro.
//  Revision    : 1.0 - initial release
// ============================================================================

// True when a control input carries an unknown value. Synthesis sees a
// constant 0 so the X branch folds away; simulation sees the real check.
`ifdef SYNTHESIS
`define COUNTER_SEQ_IS_X(sig) 1'b0
`else
`define COUNTER_SEQ_IS_X(sig) $isunknown(sig)
`endif

package counter_seq_pkg;

    // Job result codes as they appear on resp_status
    localparam logic [1:0] c_STATUS_DONE    = 2'b00;
    localparam logic [1:0] c_STATUS_TIMEOUT = 2'b01;
    localparam logic [1:0] c_STATUS_ABORT   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ST_DONE    = c_STATUS_DONE,
        ST_TIMEOUT = c_STATUS_TIMEOUT,
        ST_ABORT   = c_STATUS_ABORT
    } status_t;

endpackage : counter_seq_pkg

`default_nettype wire

// File: rtl/counter_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_ctrl_if
//  Description : Job request / job response val-rdy bundle between the lab
//                control logic (master) and the sequencing controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_seq_ctrl_if
    import counter_seq_pkg::*;
    ();

    // Request channel
    logic        req_val;
    logic        req_rdy;
    logic [15:0] req_start;
    logic [15:0] req_incr;
    logic [15:0] req_finish;

    // Response channel
    logic        resp_val;
    logic        resp_rdy;
    status_t     resp_status;
    logic [15:0] resp_steps;

    modport master (
        output req_val, req_start, req_incr, req_finish, resp_rdy,
        input  req_rdy, resp_val, resp_status, resp_steps
    );

    modport slave (
        input  req_val, req_start, req_incr, req_finish, resp_rdy,
        output req_rdy, resp_val, resp_status, resp_steps
    );

endinterface : counter_seq_ctrl_if

`default_nettype wire

// File: rtl/counter_seq_ctrl_counter.sv
`default_nettype none
// ============================================================================
//  Module      : Counter_16b_RTL
//  Description : 16-bit loadable up-counter with programmable increment and an
//                equality terminal-count flag. Holds once the terminal count
//                is reached; wraps modulo 2^16 otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module Counter_16b_RTL (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        en,
    input  wire logic        load,
    input  wire logic [15:0] start,
    input  wire logic [15:0] incr,
    input  wire logic [15:0] finish,
    output logic      [15:0] count,
    output logic             done
);

    logic [15:0] r_count;
    logic [15:0] r_finish;

    // Count register: load has priority; stepping stops on terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (load) begin
            r_count <= start;
        end else if (en && !done) begin
            r_count <= r_count + incr;
        end
    end

    // Terminal count captured alongside the start value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_finish <= 16'd0;
        end else if (load) begin
            r_finish <= finish;
        end
    end

    assign count = r_count;
    assign done  = (r_count == r_finish);

endmodule : Counter_16b_RTL

`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_ctrl
//  Description : Sequencing controller for the 16-bit counter datapath.
//                Accepts a counting job, runs the counter until it reaches
//                the terminal count, is aborted, or exhausts its step budget,
//                then presents status and step count until acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    counter_seq_ctrl_if.slave bus,
    input  wire logic         pause,
    input  wire logic         abort,
    output logic       [15:0] count,
    output logic              busy
);

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    status_t     r_status;
    status_t     w_status_nxt;
    logic        w_status_we;
    logic [15:0] r_incr;
    logic [15:0] r_steps;

    logic        w_load;
    logic        w_en;
    logic        w_step_inc;
    logic        w_req_rdy;
    logic        w_resp_val;
    logic        w_done;
    logic [15:0] w_count;

    // Next-state and control decode; unknown handshake/control inputs poison
    // the decision so they are visible rather than silently resolved
    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_status_we  = 1'b0;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_step_inc   = 1'b0;
        w_req_rdy    = 1'b0;
        w_resp_val   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_req_rdy = !rst;
                if (`COUNTER_SEQ_IS_X(bus.req_val)) begin
                    w_state_nxt = state_t'(2'bxx);
                    w_load      = 1'bx;
                    w_req_rdy   = 1'bx;
                end else if (bus.req_val && w_req_rdy) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                if (`COUNTER_SEQ_IS_X(pause) || `COUNTER_SEQ_IS_X(abort)) begin
                    w_state_nxt  = state_t'(2'bxx);
                    w_status_nxt = status_t'(2'bxx);
                    w_status_we  = 1'bx;
                    w_en         = 1'bx;
                    w_step_inc   = 1'bx;
                end else if (w_done) begin
                    // Terminal count wins even if abort arrives together
                    w_state_nxt  = S_RESP;
                    w_status_nxt = ST_DONE;
                    w_status_we  = 1'b1;
                end else if (abort) begin
                    w_state_nxt  = S_RESP;
                    w_status_nxt = ST_ABORT;
                    w_status_we  = 1'b1;
                end else if (r_steps == c_TIMEOUT) begin
                    // Budget exhausted: counter is not advanced this cycle
                    w_state_nxt  = S_RESP;
                    w_status_nxt = ST_TIMEOUT;
                    w_status_we  = 1'b1;
                end else begin
                    w_en       = !pause;
                    w_step_inc = !pause;
                end
            end

            S_RESP: begin
                w_resp_val = 1'b1;
                if (`COUNTER_SEQ_IS_X(bus.resp_rdy)) begin
                    w_state_nxt = state_t'(2'bxx);
                end else if (bus.resp_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Increment latch and step counter, both restarted on job accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_incr  <= 16'd0;
            r_steps <= 16'd0;
        end else if (w_load) begin
            r_incr  <= bus.req_incr;
            r_steps <= 16'd0;
        end else if (w_step_inc) begin
            r_steps <= r_steps + 16'd1;
        end
    end

    // Job status captured on the RUN exit decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= ST_DONE;
        end else if (w_status_we) begin
            r_status <= w_status_nxt;
        end
    end

    Counter_16b_RTL u_counter (
        .clk    (clk),
        .rst    (rst),
        .en     (w_en),
        .load   (w_load),
        .start  (bus.req_start),
        .incr   (r_incr),
        .finish (bus.req_finish),
        .count  (w_count),
        .done   (w_done)
    );

    assign bus.req_rdy     = w_req_rdy;
    assign bus.resp_val    = w_resp_val;
    assign bus.resp_status = r_status;
    assign bus.resp_steps  = r_steps;
    assign count           = w_count;
    assign busy            = (r_state != S_IDLE);

endmodule : counter_seq_ctrl

`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_seq_ctrl
//  Description : Directed self-checking bench for counter_seq_ctrl. Two
//                instances: default step budget (A) and budget of 8 (B);
//                `sel` routes the shared stimulus to one of them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;
    import counter_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_val = 1'b0;
    logic [15:0] req_start = 16'd0;
    logic [15:0] req_incr = 16'd0;
    logic [15:0] req_finish = 16'd0;
    logic        resp_rdy = 1'b0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    counter_seq_ctrl_if u_if_a ();
    counter_seq_ctrl_if u_if_b ();

    logic [15:0] count_a, count_b;
    logic        busy_a, busy_b;

    assign u_if_a.req_val    = req_val & !sel;
    assign u_if_a.req_start  = req_start;
    assign u_if_a.req_incr   = req_incr;
    assign u_if_a.req_finish = req_finish;
    assign u_if_a.resp_rdy   = resp_rdy & !sel;
    assign u_if_b.req_val    = req_val & sel;
    assign u_if_b.req_start  = req_start;
    assign u_if_b.req_incr   = req_incr;
    assign u_if_b.req_finish = req_finish;
    assign u_if_b.resp_rdy   = resp_rdy & sel;

    counter_seq_ctrl u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .bus   (u_if_a.slave),
        .pause (pause & !sel),
        .abort (abort & !sel),
        .count (count_a),
        .busy  (busy_a)
    );

    counter_seq_ctrl #(.TIMEOUT(8)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .bus   (u_if_b.slave),
        .pause (pause & sel),
        .abort (abort & sel),
        .count (count_b),
        .busy  (busy_b)
    );

    wire        o_req_rdy  = sel ? u_if_b.req_rdy     : u_if_a.req_rdy;
    wire        o_resp_val = sel ? u_if_b.resp_val    : u_if_a.resp_val;
    wire [1:0]  o_status   = sel ? u_if_b.resp_status : u_if_a.resp_status;
    wire [15:0] o_steps    = sel ? u_if_b.resp_steps  : u_if_a.resp_steps;
    wire [15:0] o_count    = sel ? count_b : count_a;
    wire        o_busy     = sel ? busy_b  : busy_a;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue a job in the current (IDLE) cycle = cycle 0, apply pause over
    // cycles p_lo..p_hi and abort in cycle a_at, return the cycle in which
    // resp_val is first seen (or -1 if it never appears)
    task automatic run_job(input logic [15:0] s, input logic [15:0] i,
                           input logic [15:0] f, input int p_lo, input int p_hi,
                           input int a_at, output int rc);
        req_start  = s;
        req_incr   = i;
        req_finish = f;
        req_val    = 1'b1;
        tick();
        req_val = 1'b0;
        rc      = -1;
        for (int c = 1; c < 300; c++) begin
            pause = (c >= p_lo) && (c <= p_hi);
            abort = (c == a_at);
            #1;
            if (o_resp_val) begin
                rc = c;
                break;
            end
            tick();
        end
        pause = 1'b0;
        abort = 1'b0;
    endtask

    // Acknowledge the pending response and confirm the return to IDLE
    task automatic handshake(input string tag);
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        #1;
        chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_idle_rdy"},  32'(o_req_rdy), 32'd1);
    endtask

    int rc;
    int seen;

    initial begin
        // Reset held: all outputs at their reset values
        repeat (3) tick();
        chk("rst_req_rdy",  32'(o_req_rdy), 32'd0);
        chk("rst_resp_val", 32'(o_resp_val), 32'd0);
        chk("rst_busy",     32'(o_busy), 32'd0);
        chk("rst_count",    32'(o_count), 32'd0);
        chk("rst_status",   32'(o_status), 32'd0);
        chk("rst_steps",    32'(o_steps), 32'd0);

        // Post-reset done=1 must not look like a completed job
        rst = 1'b0;
        #1;
        chk("idle_req_rdy", 32'(o_req_rdy), 32'd1);
        tick();
        chk("idle_resp_val", 32'(o_resp_val), 32'd0);
        chk("idle_busy",     32'(o_busy), 32'd0);

        // Basic job: 0 -> 3 by 1
        run_job(16'd0, 16'd1, 16'd3, 0, -1, -1, rc);
        chk("j1_cycle",  32'(rc), 32'd5);
        chk("j1_status", 32'(o_status), 32'(c_STATUS_DONE));
        chk("j1_steps",  32'(o_steps), 32'd3);
        chk("j1_count",  32'(o_count), 32'd3);
        handshake("j1");

        // start == finish: immediate completion
        run_job(16'd7, 16'd5, 16'd7, 0, -1, -1, rc);
        chk("j2_cycle",  32'(rc), 32'd2);
        chk("j2_status", 32'(o_status), 32'(c_STATUS_DONE));
        chk("j2_steps",  32'(o_steps), 32'd0);
        chk("j2_count",  32'(o_count), 32'd7);
        handshake("j2");

        // Overshoot on the budget-8 instance: 0,2,..,16 never equals 3
        sel = 1'b1;
        #1;
        run_job(16'd0, 16'd2, 16'd3, 0, -1, -1, rc);
        chk("to_cycle",  32'(rc), 32'd10);
        chk("to_status", 32'(o_status), 32'(c_STATUS_TIMEOUT));
        chk("to_steps",  32'(o_steps), 32'd8);
        chk("to_count",  32'(o_count), 32'd16);
        handshake("to");
        sel = 1'b0;
        #1;

        // Unpaused reference for the pause test
        run_job(16'd0, 16'd1, 16'd10, 0, -1, -1, rc);
        chk("np_cycle", 32'(rc), 32'd12);
        chk("np_steps", 32'(o_steps), 32'd10);
        handshake("np");

        // Pause over cycles 2..5 delays completion by 4 cycles
        run_job(16'd0, 16'd1, 16'd10, 2, 5, -1, rc);
        chk("pa_cycle",  32'(rc), 32'd16);
        chk("pa_status", 32'(o_status), 32'(c_STATUS_DONE));
        chk("pa_steps",  32'(o_steps), 32'd10);
        chk("pa_count",  32'(o_count), 32'd10);
        handshake("pa");

        // Abort in cycle 4
        run_job(16'd0, 16'd1, 16'd100, 0, -1, 4, rc);
        chk("ab_cycle",  32'(rc), 32'd5);
        chk("ab_status", 32'(o_status), 32'(c_STATUS_ABORT));
        chk("ab_steps",  32'(o_steps), 32'd3);
        chk("ab_count",  32'(o_count), 32'd3);
        handshake("ab");

        // Abort coincident with done: done wins
        run_job(16'd0, 16'd1, 16'd3, 0, -1, 4, rc);
        chk("abd_cycle",  32'(rc), 32'd5);
        chk("abd_status", 32'(o_status), 32'(c_STATUS_DONE));
        chk("abd_steps",  32'(o_steps), 32'd3);
        handshake("abd");

        // Wrap through 0xFFFF: FFFE -> FFFF -> 0000 -> 0001
        run_job(16'hFFFE, 16'd1, 16'd1, 0, -1, -1, rc);
        chk("wr_cycle", 32'(rc), 32'd5);
        chk("wr_steps", 32'(o_steps), 32'd3);
        chk("wr_count", 32'(o_count), 32'd1);
        handshake("wr");

        // Response held stable while resp_rdy stays low for 3 cycles
        run_job(16'd0, 16'd1, 16'd2, 0, -1, -1, rc);
        chk("hold_cycle", 32'(rc), 32'd4);
        for (int k = 0; k < 3; k++) begin
            chk("hold_val",     32'(o_resp_val), 32'd1);
            chk("hold_status",  32'(o_status), 32'(c_STATUS_DONE));
            chk("hold_steps",   32'(o_steps), 32'd2);
            chk("hold_count",   32'(o_count), 32'd2);
            chk("hold_req_rdy", 32'(o_req_rdy), 32'd0);
            tick();
            #1;
        end
        handshake("hold");

        // Asynchronous reset in the middle of a job
        req_start  = 16'd0;
        req_incr   = 16'd1;
        req_finish = 16'd100;
        req_val    = 1'b1;
        tick();
        req_val = 1'b0;
        tick();
        tick();
        chk("mr_busy_before", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_busy",     32'(o_busy), 32'd0);
        chk("mr_count",    32'(o_count), 32'd0);
        chk("mr_req_rdy",  32'(o_req_rdy), 32'd0);
        chk("mr_resp_val", 32'(o_resp_val), 32'd0);
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (o_resp_val) seen = 1;
            tick();
        end
        chk("mr_no_resp", 32'(seen), 32'd0);
        chk("mr_req_rdy_after", 32'(o_req_rdy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_counter_seq_ctrl

`default_nettype wire
